grant_router: RTL and testbench

//  Downstream stage of the 10-way request arbiter. Takes the arbiter's grant vector
//  and the requesters' valid/payload, selects one eligible source, and moves its

---
 rtl/grant_router_if.sv | 28 ++
 rtl/grant_router.sv | 72 +++++++
 tb/tb_grant_router.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/grant_router_if.sv
// Handshake bundle between the arbiter-side requesters, the grant router and the shared consumer.
// The router binds to the slave modport; the requester/consumer side binds to master.
interface grant_router_if #(
  parameter int N      = 10,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 16
);
  logic [N-1:0]        io_grant;
  logic [N-1:0]        io_req_valid;
  logic [N*DATA_W-1:0] io_req_data;
  logic [N-1:0]        io_req_ready;
  logic                io_out_valid;
  logic [DATA_W-1:0]   io_out_bits;
  logic [ID_W-1:0]     io_out_id;
  logic                io_out_ready;
  logic [CNT_W-1:0]    io_xfer_count;

  modport master (
    output io_grant, io_req_valid, io_req_data, io_out_ready,
    input  io_req_ready, io_out_valid, io_out_bits, io_out_id, io_xfer_count
  );

  modport slave (
    input  io_grant, io_req_valid, io_req_data, io_out_ready,
    output io_req_ready, io_out_valid, io_out_bits, io_out_id, io_xfer_count
  );
endinterface

// File: rtl/grant_router.sv
// Moves the lowest-index granted and valid requester's payload into a single registered
// output slot with valid/ready handshaking, and counts completed output transfers.
module grant_router #(
  parameter int N      = 10,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 16
) (
  input logic          clock,
  input logic          reset,
  grant_router_if.slave io
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] out_bits;
  logic [ID_W-1:0]   out_id;
  logic [CNT_W-1:0]  xfer_count;

  logic [N-1:0]      elig;
  logic [ID_W-1:0]   sel;
  logic [DATA_W-1:0] sel_data;
  logic              any;
  logic              load;
  logic [N-1:0]      req_ready;

  // Downward scan so the last hit, and therefore the winner, is the lowest eligible index.
  always_comb begin
    elig     = io.io_grant & io.io_req_valid;
    sel      = '0;
    sel_data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel      = ID_W'(i);
        sel_data = io.io_req_data[i*DATA_W +: DATA_W];
      end
    end
    any  = |elig;
    load = any && !reset && (state == EMPTY || io.io_out_ready);
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = load && (sel == ID_W'(i));
    end
  end

  // A draining slot may refill in the same cycle, giving one transfer per clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_bits   <= '0;
      out_id     <= '0;
      xfer_count <= '0;
    end else begin
      if (state == FULL && io.io_out_ready) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
      if (load) begin
        out_bits <= sel_data;
        out_id   <= sel;
        state    <= FULL;
      end else if (state == FULL && io.io_out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign io.io_req_ready  = req_ready;
  assign io.io_out_valid  = (state == FULL);
  assign io.io_out_bits   = out_bits;
  assign io.io_out_id     = out_id;
  assign io.io_xfer_count = xfer_count;
endmodule

// File: tb/tb_grant_router.sv
// Directed bench for grant_router: reset, single transfer, priority, streaming,
// backpressure, eligibility masking and counter wrap, with hand-computed expectations.
module tb_grant_router;
  localparam int N      = 10;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;
  localparam int CNT_W  = 16;

  logic clock;
  logic reset;
  int   compare_count;
  int   fail_count;

  grant_router_if #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  grant_router #(.N(N), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] grant, input logic [N-1:0] valid,
                               input logic out_ready);
    bus.io_grant     = grant;
    bus.io_req_valid = valid;
    bus.io_out_ready = out_ready;
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DATA_W-1:0] value);
    bus.io_req_data[idx*DATA_W +: DATA_W] = value;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    compare_count    = 0;
    fail_count       = 0;
    reset            = 1'b1;
    bus.io_grant     = '0;
    bus.io_req_valid = '0;
    bus.io_req_data  = '0;
    bus.io_out_ready = 1'b0;

    // Reset held with an eligible request present: nothing may be accepted.
    step();
    applyStimulus(10'h001, 10'h001, 1'b0);
    checkOutput("rst_req_ready", 32'(bus.io_req_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.io_out_valid), 32'h0);
    checkOutput("rst_out_bits", 32'(bus.io_out_bits), 32'h0);
    checkOutput("rst_out_id", 32'(bus.io_out_id), 32'h0);
    checkOutput("rst_count", 32'(bus.io_xfer_count), 32'h0);
    step();
    reset = 1'b0;
    applyStimulus(10'h000, 10'h000, 1'b0);

    // T2 single transfer held under backpressure
    step();
    set_data(0, 8'hA5);
    applyStimulus(10'h001, 10'h001, 1'b0);
    checkOutput("t2_req_ready", 32'(bus.io_req_ready), 32'h001);
    checkOutput("t2_valid_before", 32'(bus.io_out_valid), 32'h0);
    step();
    applyStimulus(10'h001, 10'h000, 1'b0);
    checkOutput("t2_valid", 32'(bus.io_out_valid), 32'h1);
    checkOutput("t2_bits", 32'(bus.io_out_bits), 32'hA5);
    checkOutput("t2_id", 32'(bus.io_out_id), 32'h0);
    checkOutput("t2_req_ready_idle", 32'(bus.io_req_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput("t2_hold_valid", 32'(bus.io_out_valid), 32'h1);
      checkOutput("t2_hold_bits", 32'(bus.io_out_bits), 32'hA5);
      checkOutput("t2_hold_count", 32'(bus.io_xfer_count), 32'h0);
    end
    step();
    applyStimulus(10'h001, 10'h000, 1'b1);
    checkOutput("t2_drain_count", 32'(bus.io_xfer_count), 32'h0);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("t2_count", 32'(bus.io_xfer_count), 32'h1);
    checkOutput("t2_empty", 32'(bus.io_out_valid), 32'h0);

    // T3 priority: grant 0x007, valid 0x006 selects requester 1
    step();
    set_data(1, 8'h11);
    set_data(2, 8'h22);
    applyStimulus(10'h007, 10'h006, 1'b0);
    checkOutput("t3_req_ready", 32'(bus.io_req_ready), 32'h002);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("t3_bits", 32'(bus.io_out_bits), 32'h11);
    checkOutput("t3_id", 32'(bus.io_out_id), 32'h1);
    step();
    applyStimulus(10'h000, 10'h000, 1'b1);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("t3_count", 32'(bus.io_xfer_count), 32'h2);
    checkOutput("t3_empty", 32'(bus.io_out_valid), 32'h0);

    // T4 streaming eight payloads with the consumer always ready
    for (int k = 1; k <= 8; k++) begin
      step();
      set_data(0, 8'(k));
      applyStimulus(10'h001, 10'h001, 1'b1);
      checkOutput("t4_req_ready", 32'(bus.io_req_ready), 32'h001);
      if (k > 1) begin
        checkOutput("t4_valid", 32'(bus.io_out_valid), 32'h1);
        checkOutput("t4_bits", 32'(bus.io_out_bits), 32'(k - 1));
      end
    end
    step();
    applyStimulus(10'h001, 10'h000, 1'b1);
    checkOutput("t4_last_bits", 32'(bus.io_out_bits), 32'h08);
    checkOutput("t4_last_valid", 32'(bus.io_out_valid), 32'h1);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("t4_count", 32'(bus.io_xfer_count), 32'd10);
    checkOutput("t4_empty", 32'(bus.io_out_valid), 32'h0);

    // T5 backpressure: a new request waits until the slot drains
    step();
    set_data(0, 8'h55);
    applyStimulus(10'h001, 10'h001, 1'b0);
    checkOutput("t5_first_accept", 32'(bus.io_req_ready), 32'h001);
    step();
    set_data(0, 8'h66);
    applyStimulus(10'h001, 10'h001, 1'b0);
    checkOutput("t5_blocked", 32'(bus.io_req_ready), 32'h0);
    checkOutput("t5_bits_held", 32'(bus.io_out_bits), 32'h55);
    step();
    checkOutput("t5_still_blocked", 32'(bus.io_req_ready), 32'h0);
    checkOutput("t5_bits_stable", 32'(bus.io_out_bits), 32'h55);
    applyStimulus(10'h001, 10'h001, 1'b1);
    checkOutput("t5_accept_on_ready", 32'(bus.io_req_ready), 32'h001);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("t5_new_bits", 32'(bus.io_out_bits), 32'h66);
    checkOutput("t5_valid", 32'(bus.io_out_valid), 32'h1);
    checkOutput("t5_count", 32'(bus.io_xfer_count), 32'd11);

    // T1 asynchronous reset while FULL under backpressure drops the slot
    step();
    applyStimulus(10'h002, 10'h002, 1'b0);
    checkOutput("t1_pre_req_ready", 32'(bus.io_req_ready), 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("t1_valid", 32'(bus.io_out_valid), 32'h0);
    checkOutput("t1_count", 32'(bus.io_xfer_count), 32'h0);
    checkOutput("t1_req_ready", 32'(bus.io_req_ready), 32'h0);
    checkOutput("t1_bits", 32'(bus.io_out_bits), 32'h0);
    step();
    step();
    reset = 1'b0;
    applyStimulus(10'h000, 10'h000, 1'b0);

    // T6 masking: grant without valid, and valid without grant, are ignored
    step();
    applyStimulus(10'h3FF, 10'h000, 1'b1);
    checkOutput("t6_grant_only", 32'(bus.io_req_ready), 32'h0);
    step();
    applyStimulus(10'h001, 10'h002, 1'b1);
    checkOutput("t6_valid_after_mask", 32'(bus.io_out_valid), 32'h0);
    checkOutput("t6_valid_only", 32'(bus.io_req_ready), 32'h0);
    step();
    checkOutput("t6_still_empty", 32'(bus.io_out_valid), 32'h0);
    checkOutput("t6_ready_ignored", 32'(bus.io_xfer_count), 32'h0);

    // Highest index requester wins when it is the only eligible one
    set_data(9, 8'h99);
    applyStimulus(10'h300, 10'h200, 1'b0);
    checkOutput("hi_req_ready", 32'(bus.io_req_ready), 32'h200);
    step();
    applyStimulus(10'h000, 10'h000, 1'b1);
    checkOutput("hi_id", 32'(bus.io_out_id), 32'd9);
    checkOutput("hi_bits", 32'(bus.io_out_bits), 32'h99);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("hi_count", 32'(bus.io_xfer_count), 32'h1);

    // T6 wrap: stream until the counter reaches 0xFFFF, then one more transfer
    set_data(0, 8'h3C);
    applyStimulus(10'h001, 10'h001, 1'b1);
    for (int k = 0; k < 65535; k++) begin
      step();
    end
    checkOutput("wrap_full", 32'(bus.io_xfer_count), 32'hFFFF);
    applyStimulus(10'h001, 10'h000, 1'b1);
    step();
    applyStimulus(10'h000, 10'h000, 1'b0);
    checkOutput("wrap_zero", 32'(bus.io_xfer_count), 32'h0000);
    checkOutput("wrap_empty", 32'(bus.io_out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end
endmodule
